// File: rtl/flag_unit_if.sv
// flag_unit_if: groups the flag-write stage, branch-condition and checkpoint
// signals of flag_unit into one bundle.
//   master : drives opcode/aluout/aluovfl/wr_valid/stall/flush/br_cond and
//            the ckpt_push/ckpt_pop/ckpt_restore requests; observes flag results
//   slave  : the flag unit itself (consumes requests, produces flag,
//            flag_fwd, br_taken and checkpoint FIFO status)
interface flag_unit_if #(
  parameter int DATA_W     = 16,
  parameter int CKPT_DEPTH = 4
);
  localparam int CW = $clog2(CKPT_DEPTH + 1);

  logic [3:0]        opcode;
  logic [DATA_W-1:0] aluout;
  logic              aluovfl;
  logic              wr_valid;
  logic              stall;
  logic              flush;
  logic [2:0]        br_cond;
  logic              ckpt_push;
  logic              ckpt_pop;
  logic              ckpt_restore;

  logic [2:0]        flag;
  logic [2:0]        flag_fwd;
  logic              br_taken;
  logic [CW-1:0]     ckpt_count;
  logic              ckpt_full;
  logic              ckpt_empty;
  logic              ckpt_err;

  modport master (
    output opcode, aluout, aluovfl, wr_valid, stall, flush, br_cond,
           ckpt_push, ckpt_pop, ckpt_restore,
    input  flag, flag_fwd, br_taken, ckpt_count, ckpt_full, ckpt_empty,
           ckpt_err
  );

  modport slave (
    input  opcode, aluout, aluovfl, wr_valid, stall, flush, br_cond,
           ckpt_push, ckpt_pop, ckpt_restore,
    output flag, flag_fwd, br_taken, ckpt_count, ckpt_full, ckpt_empty,
           ckpt_err
  );
endinterface

// File: rtl/flag_unit.sv
// flag_unit: architectural {z,v,n} flag register for the pipelined core.
//   - per-opcode update masks (Z_MASK/V_MASK/N_MASK), qualified by
//     wr_valid, stall, flush and ckpt_restore
//   - flag_fwd: combinational value flag takes at the next edge
//   - br_taken: 3-bit branch condition evaluated on flag_fwd
//   - CKPT_DEPTH-entry FIFO of flag snapshots for speculative branches
//     (push on prediction, pop on correct resolve, restore on mispredict)
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : flag_unit_if slave modport (ALU inputs, branch condition,
//          checkpoint requests, flag/branch/FIFO status outputs)
module flag_unit #(
  parameter int          DATA_W     = 16,
  parameter int          CKPT_DEPTH = 4,
  parameter logic [15:0] Z_MASK     = 16'h007B,
  parameter logic [15:0] V_MASK     = 16'h0003,
  parameter logic [15:0] N_MASK     = 16'h0003
) (
  input  logic          clk,
  input  logic          rst,
  flag_unit_if.slave    bus
);

  localparam int CW = $clog2(CKPT_DEPTH + 1);
  localparam int PW = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;

  localparam logic [PW-1:0] LAST_PTR = PW'(CKPT_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CKPT_DEPTH);

  // Flag state
  logic [2:0]    flag_q, flag_d;
  logic [2:0]    alu_flags;

  // Checkpoint FIFO state
  logic [2:0]    mem_q [CKPT_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          err_q, err_d;

  // Control
  logic          upd;
  logic          zc, vc, nc;
  logic          restore_hit;
  logic          push_req;
  logic          do_push, do_pop, do_clear, err_set;
  logic          fz, fv, fn;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // Flag update / forwarding
  // ---------------------------------------------------------------------
  always_comb begin
    upd = bus.wr_valid & ~bus.stall & ~bus.flush & ~bus.ckpt_restore;
    zc  = (bus.aluout == '0);
    vc  = bus.aluovfl;
    nc  = bus.aluout[DATA_W-1];
  end

  always_comb begin
    alu_flags = flag_q;
    if (upd && Z_MASK[bus.opcode]) alu_flags[2] = zc;
    if (upd && V_MASK[bus.opcode]) alu_flags[1] = vc;
    if (upd && N_MASK[bus.opcode]) alu_flags[0] = nc;
  end

  assign restore_hit = bus.ckpt_restore & ~empty_q;

  // A restore of a live checkpoint overrides the ALU result outright.
  always_comb begin
    flag_d = alu_flags;
    if (restore_hit) flag_d = mem_q[rd_ptr_q];
  end

  // ---------------------------------------------------------------------
  // Branch condition on the forwarded flags
  // ---------------------------------------------------------------------
  always_comb begin
    fz = flag_d[2];
    fv = flag_d[1];
    fn = flag_d[0];
    bus.br_taken = 1'b0;
    case (bus.br_cond)
      3'b000:  bus.br_taken = ~fz;
      3'b001:  bus.br_taken = fz;
      3'b010:  bus.br_taken = ~fz & ~fn;
      3'b011:  bus.br_taken = fn;
      3'b100:  bus.br_taken = fz | (~fz & ~fn);
      3'b101:  bus.br_taken = fn | fz;
      3'b110:  bus.br_taken = fv;
      default: bus.br_taken = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Checkpoint FIFO control
  // ---------------------------------------------------------------------
  assign push_req = bus.ckpt_push & ~bus.stall;

  // When full, a push is only legal if a pop frees the head the same cycle;
  // when empty, a paired pop is dropped silently and only the push happens.
  always_comb begin
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_clear = 1'b0;
    err_set  = 1'b0;
    if (restore_hit) begin
      do_clear = 1'b1;
    end else begin
      if (bus.ckpt_restore) err_set = 1'b1;
      if (empty_q) begin
        do_push = push_req;
        if (bus.ckpt_pop && !push_req) err_set = 1'b1;
      end else if (full_q) begin
        do_pop  = bus.ckpt_pop;
        do_push = push_req & bus.ckpt_pop;
        if (push_req && !bus.ckpt_pop) err_set = 1'b1;
      end else begin
        do_push = push_req;
        do_pop  = bus.ckpt_pop;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
    err_d   = err_q | err_set;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      flag_q   <= flag_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      err_q    <= err_d;
    end
  end

  // Snapshot storage needs no reset: entries are only read while counted valid.
  // A push always captures the post-update flag value.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= flag_d;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.flag       = flag_q;
  assign bus.flag_fwd   = flag_d;
  assign bus.ckpt_count = count_q;
  assign bus.ckpt_full  = full_q;
  assign bus.ckpt_empty = empty_q;
  assign bus.ckpt_err   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flag_unit_if #(.DATA_W(DW), .CKPT_DEPTH(DEPTH)) bus ();

  flag_unit #(
    .DATA_W(DW), .CKPT_DEPTH(DEPTH),
    .Z_MASK(16'h007B), .V_MASK(16'h0003), .N_MASK(16'h0003)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: flags as a 3-bit word {z,v,n}, snapshots as a queue
  // whose front is the oldest branch.
  logic [15:0] zm = 16'h007B;
  logic [15:0] vm = 16'h0003;
  logic [15:0] nm = 16'h0003;
  logic [2:0]  m_flag;
  logic [2:0]  m_q[$];
  logic        m_err;

  task automatic chk(input string nm_s, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm_s, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_fwd();
    logic upd, z, v, n;
    if (bus.ckpt_restore && m_q.size() != 0) return m_q[0];
    upd = bus.wr_valid && !bus.stall && !bus.flush && !bus.ckpt_restore;
    {z, v, n} = m_flag;
    if (upd && zm[bus.opcode]) z = (bus.aluout == 16'h0000);
    if (upd && vm[bus.opcode]) v = bus.aluovfl;
    if (upd && nm[bus.opcode]) n = bus.aluout[15];
    return {z, v, n};
  endfunction

  // Conditions named by meaning: eq/ne, gt/lt, ge/le, overflow, always.
  function automatic logic m_br(input logic [2:0] f, input logic [2:0] bc);
    logic z, v, n, eq, lt;
    {z, v, n} = f;
    eq = z;
    lt = n;
    case (bc)
      3'd0: return !eq;
      3'd1: return eq;
      3'd2: return !eq && !lt;
      3'd3: return lt;
      3'd4: return eq || !lt;
      3'd5: return lt || eq;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic m_commit(input logic [2:0] nf);
    int  sz;
    logic pu;
    sz = m_q.size();
    pu = bus.ckpt_push && !bus.stall;
    if (bus.ckpt_restore && sz != 0) begin
      m_q.delete();
    end else begin
      if (bus.ckpt_restore) m_err = 1'b1;
      if (bus.ckpt_pop && sz == 0 && !pu) m_err = 1'b1;
      if (pu && sz == DEPTH && !bus.ckpt_pop) m_err = 1'b1;
      if (bus.ckpt_pop && sz > 0) void'(m_q.pop_front());
      if (pu && (sz < DEPTH || bus.ckpt_pop)) m_q.push_back(nf);
    end
    m_flag = nf;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [15:0] alu, input logic ov,
                        input logic wv, input logic st, input logic fl, input logic [2:0] bc,
                        input logic pu, input logic po, input logic re);
    bus.opcode = op; bus.aluout = alu; bus.aluovfl = ov; bus.wr_valid = wv;
    bus.stall = st; bus.flush = fl; bus.br_cond = bc;
    bus.ckpt_push = pu; bus.ckpt_pop = po; bus.ckpt_restore = re;
  endtask

  task automatic chk_regs();
    chk("flag", bus.flag, m_flag);
    chk("ckpt_count", bus.ckpt_count, m_q.size());
    chk("ckpt_full", bus.ckpt_full, m_q.size() == DEPTH);
    chk("ckpt_empty", bus.ckpt_empty, m_q.size() == 0);
    chk("ckpt_err", bus.ckpt_err, m_err);
  endtask

  // Called at a negedge with inputs already driven; returns at next negedge.
  task automatic step();
    logic [2:0] ef;
    #1;
    ef = m_fwd();
    chk("flag_fwd", bus.flag_fwd, ef);
    chk("br_taken", bus.br_taken, m_br(ef, bus.br_cond));
    m_commit(ef);
    @(posedge clk); #1;
    chk_regs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(4'd0, 16'h1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    m_flag = 3'b000; m_q.delete(); m_err = 1'b0;
    @(posedge clk); #1;
    chk("rst_flag", bus.flag, 3'b000);
    chk("rst_count", bus.ckpt_count, 0);
    chk("rst_empty", bus.ckpt_empty, 1'b1);
    chk("rst_full", bus.ckpt_full, 1'b0);
    chk("rst_err", bus.ckpt_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] alu;
    logic        ov, wv, st, fl;
    logic [2:0]  bc;
    logic [2:0]  ef;
    logic        eb;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] alu, input logic ov,
                              input logic wv, input logic st, input logic fl,
                              input logic [2:0] bc, input logic [2:0] ef, input logic eb);
    vec_t v;
    v.op = op; v.alu = alu; v.ov = ov; v.wv = wv; v.st = st; v.fl = fl;
    v.bc = bc; v.ef = ef; v.eb = eb;
    return v;
  endfunction

  initial begin
    // Sequence of flag updates starting from reset flags 000.
    tbl[0]  = mk(4'd0, 16'h0000, 1, 1, 0, 0, 3'b110, 3'b110, 1);
    tbl[1]  = mk(4'd0, 16'h8000, 1, 1, 0, 0, 3'b101, 3'b011, 1);
    tbl[2]  = mk(4'd4, 16'h8000, 0, 1, 0, 0, 3'b000, 3'b011, 1);
    tbl[3]  = mk(4'd2, 16'h0000, 0, 1, 0, 0, 3'b001, 3'b011, 0);
    tbl[4]  = mk(4'd1, 16'hFFFF, 0, 1, 1, 0, 3'b110, 3'b011, 1);
    tbl[5]  = mk(4'd1, 16'hFFFF, 0, 1, 0, 1, 3'b100, 3'b011, 0);
    tbl[6]  = mk(4'd1, 16'hFFFF, 0, 1, 0, 0, 3'b011, 3'b001, 1);
    tbl[7]  = mk(4'd1, 16'hFFFF, 0, 0, 0, 0, 3'b010, 3'b001, 0);
    tbl[8]  = mk(4'd1, 16'hFFFF, 0, 0, 0, 0, 3'b111, 3'b001, 1);
    tbl[9]  = mk(4'd3, 16'h0000, 1, 1, 0, 0, 3'b001, 3'b101, 1);
    tbl[10] = mk(4'd5, 16'h1234, 1, 1, 0, 0, 3'b100, 3'b001, 0);
    tbl[11] = mk(4'd7, 16'h0000, 1, 1, 0, 0, 3'b010, 3'b001, 0);

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      set_in(tbl[i].op, tbl[i].alu, tbl[i].ov, tbl[i].wv, tbl[i].st, tbl[i].fl,
             tbl[i].bc, 1'b0, 1'b0, 1'b0);
      #1;
      chk($sformatf("tbl%0d_fwd", i), bus.flag_fwd, tbl[i].ef);
      chk($sformatf("tbl%0d_br", i), bus.br_taken, tbl[i].eb);
      step();
      chk($sformatf("tbl%0d_flag", i), bus.flag, tbl[i].ef);
    end

    // Fill the FIFO with 000,100,010,001, overflow it, then push+pop when full.
    do_reset();
    set_in(4'd0, 16'h0001, 0, 1, 0, 0, 3'd0, 1, 0, 0); step();
    set_in(4'd0, 16'h0000, 0, 1, 0, 0, 3'd0, 1, 0, 0); step();
    set_in(4'd0, 16'h0001, 1, 1, 0, 0, 3'd0, 1, 0, 0); step();
    set_in(4'd0, 16'h8000, 0, 1, 0, 0, 3'd0, 1, 0, 0); step();
    chk("full_after4", bus.ckpt_full, 1'b1);
    chk("err_before_ovf", bus.ckpt_err, 1'b0);
    set_in(4'd0, 16'h0000, 0, 0, 0, 0, 3'd0, 1, 0, 0); step();
    chk("ovf_err", bus.ckpt_err, 1'b1);
    chk("ovf_count", bus.ckpt_count, 4);
    set_in(4'd0, 16'h0000, 0, 0, 0, 0, 3'd0, 1, 1, 0); step();
    chk("pushpop_full_count", bus.ckpt_count, 4);
    set_in(4'd0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 1);
    #1 chk("head_after_pushpop", bus.flag_fwd, 3'b100);
    step();
    chk("restore_count", bus.ckpt_count, 0);

    // Restore beats push and ALU update; second restore on empty FIFO errors.
    do_reset();
    set_in(4'd0, 16'h0000, 0, 1, 0, 0, 3'd0, 1, 0, 0); step();
    set_in(4'd0, 16'h8000, 0, 1, 0, 0, 3'd0, 0, 0, 0); step();
    chk("pre_restore_flag", bus.flag, 3'b001);
    set_in(4'd0, 16'h0000, 1, 1, 0, 0, 3'd1, 1, 0, 1);
    #1 chk("restore_fwd", bus.flag_fwd, 3'b100);
    step();
    chk("restore_flag", bus.flag, 3'b100);
    chk("restore_push_ignored", bus.ckpt_count, 0);
    chk("restore_no_err", bus.ckpt_err, 1'b0);
    set_in(4'd0, 16'h0000, 1, 1, 0, 0, 3'd1, 0, 0, 1); step();
    chk("restore_empty_err", bus.ckpt_err, 1'b1);
    chk("restore_empty_hold", bus.flag, 3'b100);

    // Async reset mid-cycle with live checkpoints and a sticky error.
    do_reset();
    set_in(4'd0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 1, 0); step();
    set_in(4'd0, 16'h8000, 1, 1, 0, 0, 3'd0, 1, 0, 0); step();
    set_in(4'd0, 16'h0000, 0, 1, 0, 0, 3'd0, 1, 0, 0); step();
    chk("prereset_count", bus.ckpt_count, 2);
    set_in(4'd0, 16'h1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_flag", bus.flag, 3'b000);
    chk("async_empty", bus.ckpt_empty, 1'b1);
    chk("async_count", bus.ckpt_count, 0);
    chk("async_err", bus.ckpt_err, 1'b0);
    m_flag = 3'b000; m_q.delete(); m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0: a = 16'h0000;
        1: a = 16'h8000 | 16'($urandom_range(0, 255));
        default: a = 16'($urandom);
      endcase
      set_in(4'($urandom_range(0, 15)), a, 1'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 15) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Parametrised successor to the single-register Z/V/N flag block, for the pipelined core.
- Holds the architectural flags {z,v,n} with per-opcode update masks, stall/flush qualification, and a same-cycle forwarded flag value.
- Evaluates the 3-bit branch condition on the forwarded flags.
- Keeps a CKPT_DEPTH-entry FIFO of flag checkpoints so speculative branches can commit (pop) or restore flags on mispredict.

Parameters:
- DATA_W, 16, ALU result width; N is taken from bit DATA_W-1.
- CKPT_DEPTH, 4, checkpoint FIFO entries (>=1).
- Z_MASK, 16'h007B, bit k=1 means opcode k updates Z.
- V_MASK, 16'h0003, bit k=1 means opcode k updates V.
- N_MASK, 16'h0003, bit k=1 means opcode k updates N.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active high
- opcode  in  4  opcode of instruction in flag-write stage
- aluout  in  DATA_W  ALU result
- aluovfl  in  1  ALU signed overflow
- wr_valid  in  1  instruction in flag-write stage is valid
- stall  in  1  hold flag-write stage
- flush  in  1  kill instruction in flag-write stage
- br_cond  in  3  branch condition code
- ckpt_push  in  1  snapshot flags for a predicted branch
- ckpt_pop  in  1  oldest branch resolved correct; discard oldest snapshot
- ckpt_restore  in  1  oldest branch mispredicted; restore flags from oldest snapshot
- flag  out  3  registered flags {z,v,n}
- flag_fwd  out  3  flags as they will be after this edge (combinational)
- br_taken  out  1  branch condition evaluated on flag_fwd
- ckpt_count  out  $clog2(CKPT_DEPTH+1)  valid checkpoint entries
- ckpt_full  out  1  ckpt_count==CKPT_DEPTH
- ckpt_empty  out  1  ckpt_count==0
- ckpt_err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): flag=3'b000, FIFO emptied (pointers 0, ckpt_count=0), ckpt_empty=1, ckpt_full=0, ckpt_err=0. Takes effect immediately mid-operation; all in-flight checkpoints are lost.
- upd = wr_valid & ~stall & ~flush & ~ckpt_restore.
- Computed values: zc=(aluout=={DATA_W{1'b0}}), vc=aluovfl, nc=aluout[DATA_W-1].
- flag_fwd bit rules:
  - Z = (upd & Z_MASK[opcode]) ? zc : flag[2]; V and N likewise with V_MASK/N_MASK.
  - Unmasked bits hold.
  - When ckpt_restore with a non-empty FIFO, flag_fwd = oldest entry.
- flag <= flag_fwd every edge. Update latency: 1 cycle to flag, 0 cycles to flag_fwd/br_taken.
- br_taken, on f=flag_fwd:
  - 000: ~z
  - 001: z
  - 010: ~z&~n
  - 011: n
  - 100: z|(~z&~n)
  - 101: n|z
  - 110: v
  - 111: 1
- Checkpoint FIFO, priority restore > push/pop:
  - ckpt_restore, non-empty: flag <= oldest entry; FIFO cleared; any push/pop in the same cycle is ignored; the ALU update is dropped.
  - ckpt_restore, empty: flag updates normally (upd already forced 0, so flag holds); ckpt_err<=1.
  - ckpt_push & ~stall: writes flag_fwd (post-update value) at the tail.
  - ckpt_push with stall=1: ignored, no error.
  - ckpt_pop: removes the head; unaffected by stall/flush.
  - Push and pop in the same cycle on a non-empty FIFO: both occur, count unchanged (legal even when full).
  - Push and pop on an empty FIFO: push occurs, pop ignored, no error.
  - Push when full without pop: ignored, ckpt_err<=1.
  - Pop when empty without push: ignored, ckpt_err<=1.
- Pointers wrap modulo CKPT_DEPTH. ckpt_count, ckpt_full and ckpt_empty are registered and consistent with the pointers.
- ckpt_err is sticky until rst.

Test Plan:
- Reset then opcode=0, aluout=16'h0000, aluovfl=1, wr_valid=1:
  - flag_fwd=3'b110 the same cycle; flag=3'b110 next cycle; br_cond=110 gives br_taken=1.
- flag=3'b011, opcode=4 (SLL), aluout=16'h8000:
  - Z clears, V/N hold, flag=3'b011.
  - Then opcode=2 (XOR), aluout=0: flag unchanged (Z_MASK[2]=0).
- opcode=1, aluout=16'hFFFF with stall=1, then flush=1: flag unchanged in both cycles.
  - Next cycle with both low: flag=3'b001; br_cond=011 gives br_taken=1; br_cond=010 gives br_taken=0.
- Push four times with flags 000, 100, 010, 001:
  - ckpt_full=1.
  - 5th push: ignored, ckpt_err=1.
  - Push+pop together: count stays 4, head becomes 100.
- Push (flag=3'b100), then an ALU update sets flag=3'b001, then ckpt_restore+ckpt_push+opcode=0 update in the same cycle:
  - flag=3'b100, ckpt_count=0, push ignored.
  - ckpt_restore again: ckpt_err=1, flag holds.
- Push two entries, assert rst mid-cycle (async):
  - Outputs clear immediately; ckpt_empty=1, flag=0, ckpt_err=0.
